// File: rtl/param_lifo_stack.sv
// param_lifo_stack: parametrised LIFO store with occupancy count, registered
// top-of-stack output, sticky overflow/underflow flags and synchronous flush.
// Push and pop on the same edge replace the top entry in a single cycle.
module param_lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             clear_err,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             op_done,
    output logic             overflow,
    output logic             underflow
);

    // Array address width. Pointer arithmetic runs in CNT_W bits and is only
    // narrowed to AW after the index is known to be below DEPTH.
    localparam int AW = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] dout_q;
    logic             op_done_q;
    logic             overflow_q;
    logic             underflow_q;

    logic [CNT_W-1:0] count_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             op_done_nxt;
    logic             ovf_set;
    logic             udf_set;
    logic             wr_en;
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // The entry below the current top; only meaningful when count >= 2,
    // otherwise held at 0 so the subtraction never wraps into the index.
    assign rd_ptr  = (count_q >= CNT_TWO) ? (count_q - CNT_TWO) : '0;
    assign rd_addr = rd_ptr[AW-1:0];
    assign rd_data = mem[rd_addr];
    assign wr_addr = wr_ptr[AW-1:0];

    // Per-edge decode: rst > flush > push/pop. Write enable is gated by rst
    // and flush so unknown request inputs during reset never reach the array.
    always_comb begin
        count_nxt   = count_q;
        dout_nxt    = dout_q;
        op_done_nxt = 1'b0;
        ovf_set     = 1'b0;
        udf_set     = 1'b0;
        wr_en       = 1'b0;
        wr_ptr      = '0;

        if (rst) begin
            count_nxt   = '0;
            dout_nxt    = '0;
            op_done_nxt = 1'b0;
        end else if (flush) begin
            count_nxt   = '0;
            dout_nxt    = '0;
            op_done_nxt = 1'b1;
        end else if (push && pop && !is_empty) begin
            // Replace-top: overwrite the current top, occupancy unchanged.
            wr_en       = 1'b1;
            wr_ptr      = count_q - CNT_ONE;
            dout_nxt    = din;
            op_done_nxt = 1'b1;
        end else if (push) begin
            // Push alone, or push+pop on an empty stack (treated as push).
            if (is_full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en       = 1'b1;
                wr_ptr      = count_q;
                count_nxt   = count_q + CNT_ONE;
                dout_nxt    = din;
                op_done_nxt = 1'b1;
            end
        end else if (pop) begin
            if (is_empty) begin
                udf_set = 1'b1;
            end else if (count_q == CNT_ONE) begin
                count_nxt   = '0;
                dout_nxt    = '0;
                op_done_nxt = 1'b1;
            end else begin
                count_nxt   = count_q - CNT_ONE;
                dout_nxt    = rd_data;
                op_done_nxt = 1'b1;
            end
        end
    end

    // Storage array; intentionally not reset, dout never exposes unwritten slots.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr < CNT_FULL)) begin
            mem[wr_addr] <= din;
        end
    end

    // Occupancy, top-of-stack register and completion pulse.
    always_ff @(posedge clk) begin
        count_q   <= count_nxt;
        dout_q    <= dout_nxt;
        op_done_q <= op_done_nxt;
    end

    // Sticky error flags: a new error on the same edge beats clear_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (clear_err) begin
                overflow_q <= 1'b0;
            end
            if (udf_set) begin
                underflow_q <= 1'b1;
            end else if (clear_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign count      = count_q;
    assign dout       = dout_q;
    assign dout_valid = !is_empty;
    assign empty      = is_empty;
    assign full       = is_full;
    assign op_done    = op_done_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed bench for param_lifo_stack at DEPTH=4, WIDTH=8.
module tb_param_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             flush;
    logic             clear_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             op_done;
    logic             overflow;
    logic             underflow;

    int total = 0;
    int bad   = 0;

    param_lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .clear_err  (clear_err),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .op_done    (op_done),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request set before the edge, then sample 1 time unit after it.
    task automatic op(input logic p, input logic q, input logic f, input logic c,
                      input logic [WIDTH-1:0] d);
        @(negedge clk);
        push = p; pop = q; flush = f; clear_err = c; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0;
    endtask

    task automatic expect_state(input string tag, input int cnt, input logic [WIDTH-1:0] top,
                                input logic opd, input logic ovf, input logic udf);
        chk({tag, ".count"},      32'(count),      32'(cnt));
        chk({tag, ".dout"},       32'(dout),       32'(top));
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(cnt != 0));
        chk({tag, ".empty"},      32'(empty),      32'(cnt == 0));
        chk({tag, ".full"},       32'(full),       32'(cnt == DEPTH));
        chk({tag, ".op_done"},    32'(op_done),    32'(opd));
        chk({tag, ".overflow"},   32'(overflow),   32'(ovf));
        chk({tag, ".underflow"},  32'(underflow),  32'(udf));
    endtask

    initial begin
        // Reset with unknown request inputs; they must not leak to outputs.
        rst = 1'b1; push = 1'bx; pop = 1'bx; flush = 1'bx; clear_err = 1'bx; din = 'x;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        expect_state("reset_idle", 0, 8'h00, 0, 0, 0);

        // Fill to full, dout follows din.
        op(1, 0, 0, 0, 8'h11); expect_state("push1", 1, 8'h11, 1, 0, 0);
        op(1, 0, 0, 0, 8'h22); expect_state("push2", 2, 8'h22, 1, 0, 0);
        op(1, 0, 0, 0, 8'h33); expect_state("push3", 3, 8'h33, 1, 0, 0);
        op(1, 0, 0, 0, 8'h44); expect_state("push4", 4, 8'h44, 1, 0, 0);

        // Overflow then clear.
        op(1, 0, 0, 0, 8'h55); expect_state("overflow", 4, 8'h44, 0, 1, 0);
        op(0, 0, 0, 1, 8'h00); expect_state("clr_ovf", 4, 8'h44, 0, 0, 0);

        // Drain.
        op(0, 1, 0, 0, 8'h00); expect_state("pop1", 3, 8'h33, 1, 0, 0);
        op(0, 1, 0, 0, 8'h00); expect_state("pop2", 2, 8'h22, 1, 0, 0);
        op(0, 1, 0, 0, 8'h00); expect_state("pop3", 1, 8'h11, 1, 0, 0);
        op(0, 1, 0, 0, 8'h00); expect_state("pop4", 0, 8'h00, 1, 0, 0);

        // Underflow, then push+pop on empty behaves as push; flag stays sticky.
        op(0, 1, 0, 0, 8'h00); expect_state("underflow", 0, 8'h00, 0, 0, 1);
        op(1, 1, 0, 0, 8'h9A); expect_state("pp_empty", 1, 8'h9A, 1, 0, 1);

        // Replace-top on a 2-entry stack.
        op(0, 1, 0, 0, 8'h00); expect_state("drain9a", 0, 8'h00, 1, 0, 1);
        op(1, 0, 0, 0, 8'h11); expect_state("r_push1", 1, 8'h11, 1, 0, 1);
        op(1, 0, 0, 0, 8'h22); expect_state("r_push2", 2, 8'h22, 1, 0, 1);
        op(1, 1, 0, 0, 8'h77); expect_state("replace", 2, 8'h77, 1, 0, 1);
        op(0, 1, 0, 0, 8'h00); expect_state("r_pop", 1, 8'h11, 1, 0, 1);

        // Replace-top while full: no overflow, written entry lands at the top.
        op(1, 0, 0, 0, 8'h22); expect_state("f_push2", 2, 8'h22, 1, 0, 1);
        op(1, 0, 0, 0, 8'h33); expect_state("f_push3", 3, 8'h33, 1, 0, 1);
        op(1, 0, 0, 0, 8'h44); expect_state("f_push4", 4, 8'h44, 1, 0, 1);
        op(1, 1, 0, 0, 8'hAA); expect_state("f_replace", 4, 8'hAA, 1, 0, 1);
        op(0, 1, 0, 0, 8'h00); expect_state("f_pop", 3, 8'h33, 1, 0, 1);

        // Flush beats push; flags untouched; next push lands at slot 0.
        op(1, 0, 1, 0, 8'hBB); expect_state("flush", 0, 8'h00, 1, 0, 1);
        op(0, 0, 0, 0, 8'h00); expect_state("post_flush_idle", 0, 8'h00, 0, 0, 1);
        op(1, 0, 0, 0, 8'hCC); expect_state("push_after_flush", 1, 8'hCC, 1, 0, 1);
        op(1, 0, 0, 0, 8'hDD); expect_state("push_after_flush2", 2, 8'hDD, 1, 0, 1);
        op(0, 1, 0, 0, 8'h00); expect_state("pop_after_flush", 1, 8'hCC, 1, 0, 1);

        // Error set beats clear_err on the same edge; clear alone clears.
        op(0, 1, 0, 0, 8'h00); expect_state("empty_again", 0, 8'h00, 1, 0, 1);
        op(0, 1, 0, 1, 8'h00); expect_state("set_wins", 0, 8'h00, 0, 0, 1);
        op(0, 0, 0, 1, 8'h00); expect_state("clr_udf", 0, 8'h00, 0, 0, 0);

        // Reset with a push on a 2-entry stack: request is discarded.
        op(1, 0, 0, 0, 8'h01); expect_state("pre_rst1", 1, 8'h01, 1, 0, 0);
        op(1, 0, 0, 0, 8'h02); expect_state("pre_rst2", 2, 8'h02, 1, 0, 0);
        op(0, 0, 0, 0, 8'h00); expect_state("pre_rst_idle", 2, 8'h02, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; push = 1'b1; din = 8'h03;
        @(posedge clk);
        #1;
        rst = 1'b0; push = 1'b0;
        expect_state("rst_push", 0, 8'h00, 0, 0, 0);
        op(0, 0, 0, 0, 8'h00); expect_state("post_rst_idle", 0, 8'h00, 0, 0, 0);
        op(1, 0, 0, 0, 8'h04); expect_state("post_rst_push1", 1, 8'h04, 1, 0, 0);
        op(1, 0, 0, 0, 8'h05); expect_state("post_rst_push2", 2, 8'h05, 1, 0, 0);
        op(0, 1, 0, 0, 8'h00); expect_state("post_rst_pop", 1, 8'h04, 1, 0, 0);
        op(0, 1, 0, 0, 8'h00); expect_state("post_rst_pop2", 0, 8'h00, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
